// File: rtl/alu_pkg.sv
// Shared ALU encodings: the 4-bit control word seen by the 64-bit ALU
// and the 2-bit alu_op class produced by the main decoder.
package alu_pkg;

  // ALU control word: [3] Ainvert, [2] Bnegate/carry-in, [1:0] result select
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  // Instruction class as seen by the ALU control decoder
  typedef enum logic [1:0] {
    ALUOP_LDST   = 2'b00,
    ALUOP_BR     = 2'b01,
    ALUOP_RTYPE  = 2'b10,
    ALUOP_IARITH = 2'b11
  } alu_op_e;

  // funct3 values that the ALU supports for R-type and I-arith
  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_SLT    = 3'b010;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational ALU control decoder: maps alu_op/funct3/funct7[5] onto
// the ALU control word and flags combinations the ALU cannot execute.
module alu_ctrl_dec
  import alu_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_5_i,
  output logic [3:0] alu_ctrl_o,
  output logic       illegal_o
);

  // Unsupported encodings fall back to ADD so the datapath stays harmless
  always_comb begin
    alu_ctrl_o = ALU_ADD;
    illegal_o  = 1'b0;
    case (alu_op_e'(alu_op_i))
      ALUOP_LDST: alu_ctrl_o = ALU_ADD;
      ALUOP_BR:   alu_ctrl_o = ALU_SUB;
      ALUOP_RTYPE, ALUOP_IARITH: begin
        case (funct3_i)
          F3_ADDSUB: alu_ctrl_o = (alu_op_i == ALUOP_RTYPE && funct7_5_i) ? ALU_SUB : ALU_ADD;
          F3_AND:    alu_ctrl_o = ALU_AND;
          F3_OR:     alu_ctrl_o = ALU_OR;
          F3_SLT:    alu_ctrl_o = ALU_SLT;
          default:   illegal_o  = 1'b1;
        endcase
        // R-type only uses bit 30 to select SUB; anywhere else it is invalid
        if (alu_op_i == ALUOP_RTYPE && funct7_5_i && funct3_i != F3_ADDSUB) begin
          illegal_o = 1'b1;
        end
        if (illegal_o) begin
          alu_ctrl_o = ALU_ADD;
        end
      end
      default: alu_ctrl_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// Decode/execute pipeline register with valid/ready flow control,
// operand-B selection and registered ALU control word.
module id_ex_stage
  import alu_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_rs1_data,
  input  logic [XLEN-1:0]   in_rs2_data,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_alu_src,
  input  logic [1:0]        in_alu_op,
  input  logic [2:0]        in_funct3,
  input  logic              in_funct7_5,
  input  logic              in_reg_write,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic              in_branch,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_a,
  output logic [XLEN-1:0]   out_b,
  output logic [3:0]        out_alu_ctrl,
  output logic [XLEN-1:0]   out_store_data,
  output logic [XLEN-1:0]   out_pc,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_reg_write,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic              out_branch,
  output logic              out_illegal
);

  logic              accept;
  logic              drain;
  logic [XLEN-1:0]   opB_d;
  logic [3:0]        aluCtrl_d;
  logic              illegal_d;

  logic              outValid_q;
  logic [XLEN-1:0]   opA_q;
  logic [XLEN-1:0]   opB_q;
  logic [3:0]        aluCtrl_q;
  logic [XLEN-1:0]   storeData_q;
  logic [XLEN-1:0]   pc_q;
  logic [REG_AW-1:0] rd_q;
  logic              regWrite_q;
  logic              memRead_q;
  logic              memWrite_q;
  logic              branch_q;
  logic              illegal_q;

  alu_ctrl_dec uAluCtrlDec (
    .alu_op_i   (in_alu_op),
    .funct3_i   (in_funct3),
    .funct7_5_i (in_funct7_5),
    .alu_ctrl_o (aluCtrl_d),
    .illegal_o  (illegal_d)
  );

  assign in_ready = !outValid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;
  assign drain    = outValid_q && out_ready && !accept;
  assign opB_d    = in_alu_src ? in_imm : in_rs2_data;

  // Pipeline register bank: flush beats accept beats drain; otherwise hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outValid_q  <= 1'b0;
      opA_q       <= '0;
      opB_q       <= '0;
      aluCtrl_q   <= ALU_AND;
      storeData_q <= '0;
      pc_q        <= '0;
      rd_q        <= '0;
      regWrite_q  <= 1'b0;
      memRead_q   <= 1'b0;
      memWrite_q  <= 1'b0;
      branch_q    <= 1'b0;
      illegal_q   <= 1'b0;
    end else if (flush || drain) begin
      outValid_q <= 1'b0;
      regWrite_q <= 1'b0;
      memRead_q  <= 1'b0;
      memWrite_q <= 1'b0;
      branch_q   <= 1'b0;
      illegal_q  <= 1'b0;
    end else if (accept) begin
      outValid_q  <= 1'b1;
      opA_q       <= in_rs1_data;
      opB_q       <= opB_d;
      aluCtrl_q   <= aluCtrl_d;
      storeData_q <= in_rs2_data;
      pc_q        <= in_pc;
      rd_q        <= in_rd;
      regWrite_q  <= in_reg_write && !illegal_d;
      memRead_q   <= in_mem_read && !illegal_d;
      memWrite_q  <= in_mem_write && !illegal_d;
      branch_q    <= in_branch;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid      = outValid_q;
  assign out_a          = opA_q;
  assign out_b          = opB_q;
  assign out_alu_ctrl   = aluCtrl_q;
  assign out_store_data = storeData_q;
  assign out_pc         = pc_q;
  assign out_rd         = rd_q;
  assign out_reg_write  = regWrite_q;
  assign out_mem_read   = memRead_q;
  assign out_mem_write  = memWrite_q;
  assign out_branch     = branch_q;
  assign out_illegal    = illegal_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios followed by
// randomized traffic, all compared against a transaction-level model.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pc;
  logic [63:0] in_rs1_data;
  logic [63:0] in_rs2_data;
  logic [63:0] in_imm;
  logic [4:0]  in_rd;
  logic        in_alu_src;
  logic [1:0]  in_alu_op;
  logic [2:0]  in_funct3;
  logic        in_funct7_5;
  logic        in_reg_write;
  logic        in_mem_read;
  logic        in_mem_write;
  logic        in_branch;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_a;
  logic [63:0] out_b;
  logic [3:0]  out_alu_ctrl;
  logic [63:0] out_store_data;
  logic [63:0] out_pc;
  logic [4:0]  out_rd;
  logic        out_reg_write;
  logic        out_mem_read;
  logic        out_mem_write;
  logic        out_branch;
  logic        out_illegal;

  int testCount = 0;
  int failCount = 0;

  // Model of what execute should currently hold
  logic        mValid;
  logic [63:0] mA, mB, mStore, mPc;
  logic [3:0]  mCtrl;
  logic [4:0]  mRd;
  logic        mRw, mMr, mMw, mBr, mIll;

  logic [63:0] snapA;
  logic [3:0]  snapCtrl;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(64), .REG_AW(5)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_pc          (in_pc),
    .in_rs1_data    (in_rs1_data),
    .in_rs2_data    (in_rs2_data),
    .in_imm         (in_imm),
    .in_rd          (in_rd),
    .in_alu_src     (in_alu_src),
    .in_alu_op      (in_alu_op),
    .in_funct3      (in_funct3),
    .in_funct7_5    (in_funct7_5),
    .in_reg_write   (in_reg_write),
    .in_mem_read    (in_mem_read),
    .in_mem_write   (in_mem_write),
    .in_branch      (in_branch),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_a          (out_a),
    .out_b          (out_b),
    .out_alu_ctrl   (out_alu_ctrl),
    .out_store_data (out_store_data),
    .out_pc         (out_pc),
    .out_rd         (out_rd),
    .out_reg_write  (out_reg_write),
    .out_mem_read   (out_mem_read),
    .out_mem_write  (out_mem_write),
    .out_branch     (out_branch),
    .out_illegal    (out_illegal)
  );

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Expected ALU operation by name, then translated to its control word
  function automatic logic [4:0] refDecode(input logic [1:0] op, input logic [2:0] f3, input logic f7);
    string opName;
    opName = "ILL";
    if (op == 2'b00) opName = "ADD";
    else if (op == 2'b01) opName = "SUB";
    else if (f3 == 3'b000) opName = (op == 2'b10 && f7) ? "SUB" : "ADD";
    else if (op == 2'b10 && f7) opName = "ILL";
    else if (f3 == 3'b111) opName = "AND";
    else if (f3 == 3'b110) opName = "OR";
    else if (f3 == 3'b010) opName = "SLT";
    case (opName)
      "AND":   return {1'b0, 4'b0000};
      "OR":    return {1'b0, 4'b0001};
      "ADD":   return {1'b0, 4'b0010};
      "SUB":   return {1'b0, 4'b0110};
      "SLT":   return {1'b0, 4'b0111};
      default: return {1'b1, 4'b0010};
    endcase
  endfunction

  task automatic modelReset();
    mValid = 0; mA = '0; mB = '0; mStore = '0; mPc = '0; mCtrl = 4'b0000;
    mRd = '0; mRw = 0; mMr = 0; mMw = 0; mBr = 0; mIll = 0;
  endtask

  // Compare every output; data fields only matter while an instruction is held
  task automatic checkState(input string tag, input bit forceData);
    checkOutput({tag, " valid"}, 64'(out_valid), 64'(mValid));
    checkOutput({tag, " reg_write"}, 64'(out_reg_write), 64'(mRw));
    checkOutput({tag, " mem_read"}, 64'(out_mem_read), 64'(mMr));
    checkOutput({tag, " mem_write"}, 64'(out_mem_write), 64'(mMw));
    checkOutput({tag, " branch"}, 64'(out_branch), 64'(mBr));
    checkOutput({tag, " illegal"}, 64'(out_illegal), 64'(mIll));
    if (mValid || forceData) begin
      checkOutput({tag, " a"}, out_a, mA);
      checkOutput({tag, " b"}, out_b, mB);
      checkOutput({tag, " alu_ctrl"}, 64'(out_alu_ctrl), 64'(mCtrl));
      checkOutput({tag, " store_data"}, out_store_data, mStore);
      checkOutput({tag, " pc"}, out_pc, mPc);
      checkOutput({tag, " rd"}, 64'(out_rd), 64'(mRd));
    end
  endtask

  task automatic randomizeInputs();
    in_pc        = {$urandom, $urandom};
    in_rs1_data  = {$urandom, $urandom};
    in_rs2_data  = {$urandom, $urandom};
    in_imm       = {$urandom, $urandom};
    in_rd        = 5'($urandom);
    in_alu_src   = 1'($urandom);
    in_alu_op    = 2'($urandom);
    in_funct3    = 3'($urandom);
    in_funct7_5  = 1'($urandom);
    in_reg_write = 1'($urandom);
    in_mem_read  = 1'($urandom);
    in_mem_write = 1'($urandom);
    in_branch    = 1'($urandom);
  endtask

  // One cycle: drive handshake inputs, check in_ready, clock, update model, check outputs
  task automatic applyStimulus(input string tag, input logic iv, input logic ordy, input logic fl);
    logic [4:0] dec;
    logic       acc;
    in_valid  = iv;
    out_ready = ordy;
    flush     = fl;
    #1;
    checkOutput({tag, " in_ready"}, 64'(in_ready), 64'(!mValid || ordy));
    @(posedge clk);
    acc = iv && (!mValid || ordy) && !fl;
    if (fl) begin
      mValid = 0; mRw = 0; mMr = 0; mMw = 0; mBr = 0; mIll = 0;
    end else if (acc) begin
      dec    = refDecode(in_alu_op, in_funct3, in_funct7_5);
      mValid = 1;
      mA     = in_rs1_data;
      mB     = in_alu_src ? in_imm : in_rs2_data;
      mStore = in_rs2_data;
      mPc    = in_pc;
      mRd    = in_rd;
      mCtrl  = dec[3:0];
      mIll   = dec[4];
      mRw    = in_reg_write && !dec[4];
      mMr    = in_mem_read && !dec[4];
      mMw    = in_mem_write && !dec[4];
      mBr    = in_branch;
    end else if (mValid && ordy) begin
      mValid = 0; mRw = 0; mMr = 0; mMw = 0; mBr = 0; mIll = 0;
    end
    #2;
    checkState(tag, 1'b0);
  endtask

  initial begin
    // Reset held with random inputs toggling
    rst_n = 1'b0;
    modelReset();
    for (int i = 0; i < 3; i++) begin
      randomizeInputs();
      in_valid = 1'($urandom); out_ready = 1'($urandom); flush = 1'($urandom);
      @(negedge clk);
    end
    checkState("reset", 1'b1);
    in_valid = 0; out_ready = 1; flush = 0;
    rst_n = 1'b1;
    @(negedge clk);

    // R-type SUB
    randomizeInputs();
    in_alu_op = 2'b10; in_funct3 = 3'b000; in_funct7_5 = 1; in_alu_src = 0;
    in_rs1_data = 64'd5; in_rs2_data = 64'd7;
    applyStimulus("sub", 1, 1, 0);
    checkOutput("sub const ctrl", 64'(out_alu_ctrl), 64'h6);
    checkOutput("sub const a", out_a, 64'd5);
    checkOutput("sub const b", out_b, 64'd7);

    // I-type SLTI with all-ones immediate
    randomizeInputs();
    in_alu_op = 2'b11; in_funct3 = 3'b010; in_alu_src = 1; in_imm = '1;
    applyStimulus("slti", 1, 1, 0);
    checkOutput("slti const ctrl", 64'(out_alu_ctrl), 64'h7);
    checkOutput("slti const b", out_b, 64'hFFFF_FFFF_FFFF_FFFF);

    // Stall three cycles with a new instruction waiting, then release
    snapA = out_a;
    snapCtrl = out_alu_ctrl;
    randomizeInputs();
    in_alu_op = 2'b00;
    for (int i = 0; i < 3; i++) begin
      applyStimulus("stall", 1, 0, 0);
      checkOutput("stall const in_ready", 64'(in_ready), 64'h0);
      checkOutput("stall const a", out_a, snapA);
      checkOutput("stall const ctrl", 64'(out_alu_ctrl), 64'(snapCtrl));
    end
    applyStimulus("release", 1, 1, 0);
    checkOutput("release const ctrl", 64'(out_alu_ctrl), 64'h2);
    checkOutput("release const a", out_a, in_rs1_data);

    // Flush while holding and offering a new instruction
    randomizeInputs();
    applyStimulus("flush", 1, 0, 1);
    checkOutput("flush const valid", 64'(out_valid), 64'h0);

    // Illegal R-type funct3
    randomizeInputs();
    in_alu_op = 2'b10; in_funct3 = 3'b001; in_reg_write = 1;
    applyStimulus("illegal", 1, 1, 0);
    checkOutput("illegal const flag", 64'(out_illegal), 64'h1);
    checkOutput("illegal const reg_write", 64'(out_reg_write), 64'h0);
    checkOutput("illegal const ctrl", 64'(out_alu_ctrl), 64'h2);

    // Asynchronous reset in the middle of a stall
    applyStimulus("prestall", 0, 0, 0);
    #1;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkState("async reset", 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Randomized traffic with mostly legal decodes
    for (int i = 0; i < 400; i++) begin
      randomizeInputs();
      if ($urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 3))
          0: in_funct3 = 3'b000;
          1: in_funct3 = 3'b010;
          2: in_funct3 = 3'b110;
          default: in_funct3 = 3'b111;
        endcase
      end
      applyStimulus("random", 1'($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 9) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
